// File: rtl/switches_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : switches_if                                                  |
// | Description : CPU-side register access bus for the switches peripheral.    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface switches_if;
    logic        en;
    logic        wr_en;
    logic [1:0]  addr;
    logic [15:0] data;
    logic [15:0] data_out;
    logic        irq;

    modport master (
        output en,
        output wr_en,
        output addr,
        output data,
        input  data_out,
        input  irq
    );

    modport slave (
        input  en,
        input  wr_en,
        input  addr,
        input  data,
        output data_out,
        output irq
    );
endinterface
`default_nettype wire

// File: rtl/switches.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : switches                                                     |
// | Description : Synchronised, debounced switch inputs with sticky rising-    |
// |               edge flags, W1C clear and a maskable level interrupt.        |
// |               Define SWITCHES_DEBOUNCE_EN to build the debounce counters.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module switches #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_in,
    switches_if.slave        bus
);
    localparam logic [1:0] c_addr_level = 2'd0;
    localparam logic [1:0] c_addr_flags = 2'd1;
    localparam logic [1:0] c_addr_mask  = 2'd2;

    if ((WIDTH < 1) || (WIDTH > 16) || (DEBOUNCE_CYCLES < 1)) begin : g_bad_cfg
        $error("switches: WIDTH must be 1..16 and DEBOUNCE_CYCLES at least 1");
    end

    logic [WIDTH-1:0] sync_meta_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] level_q;
    logic [WIDTH-1:0] level_d;
    logic [WIDTH-1:0] level_prev_q;
    logic [WIDTH-1:0] flags_q;
    logic [WIDTH-1:0] flags_d;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic [15:0]      data_out_q;
    logic [15:0]      data_out_d;

    logic             w_rd;
    logic             w_wr;
    logic [WIDTH-1:0] w_clr;
    logic             w_unused_data;

    assign w_rd          = bus.en & ~bus.wr_en;
    assign w_wr          = bus.en &  bus.wr_en;
    assign w_unused_data = ^bus.data;

`ifdef SWITCHES_DEBOUNCE_EN
    localparam int c_cnt_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic [c_cnt_w-1:0] cnt_q [WIDTH];
    logic [c_cnt_w-1:0] cnt_d [WIDTH];

    // Counter tracks consecutive cycles the synchronised pin disagrees with level.
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == c_cnt_max) begin
                level_d[i] = sync_q[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '{default: '0};
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    always_comb begin
        level_d = sync_q;
    end
`endif

    // A W1C and a new rising edge on the same bit in one cycle leave the flag set.
    always_comb begin
        w_clr = '0;
        if (w_wr && (bus.addr == c_addr_flags)) begin
            w_clr = bus.data[WIDTH-1:0];
        end
        flags_d = (flags_q & ~w_clr) | (level_q & ~level_prev_q);

        mask_d = mask_q;
        if (w_wr && (bus.addr == c_addr_mask)) begin
            mask_d = bus.data[WIDTH-1:0];
        end

        data_out_d = data_out_q;
        if (w_rd) begin
            case (bus.addr)
                c_addr_level: data_out_d = 16'(level_q);
                c_addr_flags: data_out_d = 16'(flags_q);
                c_addr_mask:  data_out_d = 16'(mask_q);
                default:      data_out_d = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_meta_q  <= '0;
            sync_q       <= '0;
            level_q      <= '0;
            level_prev_q <= '0;
            flags_q      <= '0;
            mask_q       <= '0;
            data_out_q   <= '0;
        end else begin
            sync_meta_q  <= sw_in;
            sync_q       <= sync_meta_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            flags_q      <= flags_d;
            mask_q       <= mask_d;
            data_out_q   <= data_out_d;
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.irq      = |(flags_q & mask_q);

endmodule
`default_nettype wire

// File: tb/tb_switches.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_switches                                                  |
// | Description : Directed bench for switches with a pin-history model.        |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_switches;
`ifdef SWITCHES_DEBOUNCE_EN
    localparam int EFF_D = 4;
`else
    localparam int EFF_D = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sw_in;

    switches_if bus ();

    switches #(
        .WIDTH           (8),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .sw_in (sw_in),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a pin is accepted once the last EFF_D synchronised samples all agree.
    logic [7:0]  hist [0:8191];
    int          e;
    logic [7:0]  m_level, m_prev, m_flags, m_mask;
    logic [15:0] m_dout;

    function automatic logic [7:0] pin(input int k);
        return (k >= 1 && k <= 8191) ? hist[k] : 8'h00;
    endfunction

    always @(posedge clk or negedge rst) begin
        logic [7:0] nl, nf, nm, clr;
        logic       v, ok;
        if (!rst) begin
            e = 0; m_level = '0; m_prev = '0; m_flags = '0; m_mask = '0; m_dout = '0;
        end else begin
            e = e + 1;
            if (e <= 8191) hist[e] = sw_in;
            nl = m_level;
            for (int b = 0; b < 8; b++) begin
                v  = pin(e - 2)[b];
                ok = 1'b1;
                for (int j = 0; j < EFF_D; j++) if (pin(e - 2 - j)[b] != v) ok = 1'b0;
                if (ok && v != m_level[b]) nl[b] = v;
            end
            clr = (bus.en && bus.wr_en && bus.addr == 2'd1) ? bus.data[7:0] : 8'h00;
            nf  = (m_flags & ~clr) | (m_level & ~m_prev);
            nm  = (bus.en && bus.wr_en && bus.addr == 2'd2) ? bus.data[7:0] : m_mask;
            if (bus.en && !bus.wr_en) begin
                case (bus.addr)
                    2'd0:    m_dout = {8'h00, m_level};
                    2'd1:    m_dout = {8'h00, m_flags};
                    2'd2:    m_dout = {8'h00, m_mask};
                    default: m_dout = 16'h0000;
                endcase
            end
            m_prev  = m_level;
            m_level = nl;
            m_flags = nf;
            m_mask  = nm;
        end
    end

    always @(negedge clk) begin
        check("cyc_data_out", bus.data_out, m_dout);
        check("cyc_irq", {15'b0, bus.irq}, {15'b0, |(m_flags & m_mask)});
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
        bus.en = 1'b1; bus.wr_en = 1'b1; bus.addr = a; bus.data = d;
        @(posedge clk);
        #1;
        bus.en = 1'b0; bus.wr_en = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, input string name, input logic [15:0] exp);
        bus.en = 1'b1; bus.wr_en = 1'b0; bus.addr = a;
        @(posedge clk);
        #1;
        bus.en = 1'b0;
        check(name, bus.data_out, exp);
    endtask

    initial begin
        rst = 1'b1; sw_in = 8'h00;
        bus.en = 1'b0; bus.wr_en = 1'b0; bus.addr = 2'd0; bus.data = 16'h0000;
        #2 rst = 1'b0;
        idle(3);
        check("rst_dout", bus.data_out, 16'h0000);
        check("rst_irq", {15'b0, bus.irq}, 16'h0000);

        // Pins high at release: level rises after the debounce latency.
        sw_in = 8'hFF; rst = 1'b1;
        for (int k = 1; k <= 4 + EFF_D; k++)
            bus_read(2'd0, "lvl_rise", (k >= 3 + EFF_D) ? 16'h00FF : 16'h0000);
        bus_read(2'd1, "flags_rise", 16'h00FF);
        bus_write(2'd2, 16'h00FF);
        check("irq_armed", {15'b0, bus.irq}, 16'h0001);

        // Reset in the middle of a pending change.
        sw_in = 8'h00;
        idle(2);
        rst = 1'b0;
        #2;
        check("mid_rst_dout", bus.data_out, 16'h0000);
        check("mid_rst_irq", {15'b0, bus.irq}, 16'h0000);
        sw_in = 8'hFF;
        @(posedge clk);
        #1 rst = 1'b1;
        bus_read(2'd1, "rst_flags", 16'h0000);
        bus_read(2'd2, "rst_mask", 16'h0000);
        bus_read(2'd0, "rst_level", 16'h0000);
        bus_read(2'd3, "rst_addr3", 16'h0000);
        idle(EFF_D + 2);
        bus_read(2'd0, "lvl_after_rst", 16'h00FF);
        bus_read(2'd1, "flags_after_rst", 16'h00FF);

        // Short glitch and held press on bit 0.
        sw_in = 8'h00;
        idle(EFF_D + 4);
        bus_write(2'd1, 16'h00FF);
        bus_read(2'd1, "flags_clr", 16'h0000);
        bus_read(2'd0, "lvl_low", 16'h0000);
        bus_write(2'd2, 16'h0001);
        sw_in = 8'h01;
        idle(3);
        sw_in = 8'h00;
        idle(EFF_D + 6);
        bus_read(2'd0, "glitch_lvl", 16'h0000);
        bus_read(2'd1, "glitch_flags", (EFF_D <= 3) ? 16'h0001 : 16'h0000);
        bus_write(2'd1, 16'h00FF);
        sw_in = 8'h01;
        for (int k = 1; k <= 4 + EFF_D; k++)
            bus_read(2'd0, "hold_lvl", (k >= 3 + EFF_D) ? 16'h0001 : 16'h0000);
        bus_read(2'd1, "hold_flags", 16'h0001);

        // Write-1-to-clear, and set beating clear.
        sw_in = 8'h05;
        idle(EFF_D + 4);
        bus_read(2'd1, "w1c_pre", 16'h0005);
        bus_write(2'd1, 16'h0001);
        bus_read(2'd1, "w1c_one", 16'h0004);
        sw_in = 8'h01;
        idle(EFF_D + 4);
        sw_in = 8'h05;
        idle(2 + EFF_D);
        bus_write(2'd1, 16'h0004);
        bus_read(2'd1, "set_wins", 16'h0004);

        // Interrupt masking.
        bus_write(2'd1, 16'h00FF);
        bus_write(2'd2, 16'h0000);
        sw_in = 8'h07;
        idle(EFF_D + 4);
        bus_read(2'd1, "irq_flags", 16'h0002);
        check("irq_masked", {15'b0, bus.irq}, 16'h0000);
        bus_write(2'd2, 16'h0002);
        check("irq_unmasked", {15'b0, bus.irq}, 16'h0001);
        bus_read(2'd2, "mask_rb", 16'h0002);
        bus_write(2'd1, 16'h0002);
        check("irq_cleared", {15'b0, bus.irq}, 16'h0000);

        // Bus corners.
        bus_read(2'd3, "addr3", 16'h0000);
        bus_write(2'd0, 16'hFFFF);
        bus_read(2'd0, "lvl_ro", 16'h0007);
        bus_read(2'd2, "hold_src", 16'h0002);
        for (int k = 0; k < 5; k++) begin
            idle(1);
            check("dout_idle_hold", bus.data_out, 16'h0002);
        end
        bus_write(2'd2, 16'h0000);
        check("dout_wr_hold", bus.data_out, 16'h0002);
        bus_write(2'd3, 16'hFFFF);
        bus_read(2'd3, "addr3_wr", 16'h0000);

        // One-cycle pulse on bit 7.
        sw_in = 8'h87;
        idle(1);
        sw_in = 8'h07;
        idle(2);
        bus_read(2'd0, "pulse_lvl", (EFF_D == 1) ? 16'h0087 : 16'h0007);
        bus_read(2'd1, "pulse_flags", (EFF_D == 1) ? 16'h0080 : 16'h0000);

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/switches.md
# switches

Memory-mapped input peripheral: the read-side counterpart of the LED output register. It samples a bank of external switches and buttons, synchronises and debounces them, and latches rising edges as sticky press flags. The CPU reads these through the same `en`/`wr_en` peripheral strobe used by the other I/O blocks. A maskable level interrupt is raised while any unmasked flag is set.

## Interface
- `WIDTH`, 8: number of input pins, 1..16.
- `DEBOUNCE_CYCLES`, 16: consecutive stable synchronised cycles required to accept a new level, ≥1. The counter is sized to hold `DEBOUNCE_CYCLES-1`.

- `clk`  in  1  single system clock; all state is on its rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `en`  in  1  peripheral select strobe, one cycle per access.
- `wr_en`  in  1  1 = write access, 0 = read access; ignored when `en`=0.
- `addr`  in  2  register select.
- `data`  in  16  write data.
- `sw_in`  in  WIDTH  raw asynchronous pin inputs.
- `data_out`  out  16  registered read data; reset 0.
- `irq`  out  1  `|(flags & mask)`; combinational from registers; reset 0.

## Operation
- Registers (unused upper bits read 0, writes to them ignored):
  - addr 0 LEVEL: RO debounced levels. Writes are ignored.
  - addr 1 FLAGS: sticky rising-edge flags. Read returns the flags. Write-1-to-clear: bits with `data[i]`=1 clear.
  - addr 2 MASK: RW interrupt mask; reset 0.
  - addr 3: reads 0, writes ignored.
- Input path per bit: 2-flop synchroniser `sync`, then debouncer, then `level` register.
- Debouncer per bit:
  - If `sync[i]`==`level[i]`, the counter clears.
  - Otherwise the counter increments.
  - When the counter equals `DEBOUNCE_CYCLES-1` and the bits still differ, `level[i]` takes `sync[i]` and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles never reaches `level`.
- Edge detect: `level_d` is a one-cycle-delayed copy of `level`. `flags[i]` sets when `level[i] & ~level_d[i]`. Falling edges set nothing.
- Simultaneous set and W1C of the same bit in the same cycle: set wins, and the flag stays 1.
- Read: when `en`=1 and `wr_en`=0, `data_out` loads the addressed register on that edge. It holds its value otherwise, including during writes.
- Reset mid-operation asynchronously clears the following, all returning to 0 with no partial state retained:
  - `sync`, counters, `level`, `level_d`, `flags`, `mask`, `data_out`.
- If pins are high when reset releases, `level` rises after the debounce latency and sets the corresponding flags. This is intended; software clears them at boot.

## Timing
- Pin change stable before edge 1:
  - `sync` output reflects it after edge 2.
  - `level` updates at edge 2+`DEBOUNCE_CYCLES`.
  - `flags` set at edge 3+`DEBOUNCE_CYCLES`.
  - `irq` asserts in the same cycle as the flag, if the bit is unmasked.
- Read latency: 1 cycle. `data_out` is valid after the edge that samples `en`.
- A write to FLAGS or MASK takes effect at the sampling edge. A read issued in the next cycle returns the new value. `irq` follows combinationally.
- Back-to-back accesses in every cycle are supported. There is no wait state.

## Configuration
- `SWITCHES_DEBOUNCE_EN` defined: debouncer as specified above.
- `SWITCHES_DEBOUNCE_EN` undefined:
  - The counters are not built.
  - `level` loads `sync` every cycle, which behaves exactly as `DEBOUNCE_CYCLES`=1.
  - `DEBOUNCE_CYCLES` is ignored.
  - Latency is pin change to `level` at edge 3, and to flag at edge 4.

## Test plan
Benches use `WIDTH`=8 and `DEBOUNCE_CYCLES`=4.
- Reset: assert `rst`=0 mid-count with `sw_in`=0xFF. Required: `data_out`, `irq`, LEVEL, FLAGS and MASK all read 0x0000 after release. LEVEL reads 0x00FF only after 6 cycles, and FLAGS then reads 0x00FF.
- Debounce: `sw_in[0]` pulses high for 3 cycles → LEVEL stays 0x0000 and FLAGS stays 0x0000. Held high 4+ cycles → LEVEL becomes 0x0001 at edge 6 and FLAGS becomes 0x0001 at edge 7.
- W1C: with FLAGS=0x0005, write 0x0001 to addr 1 → FLAGS reads 0x0004. A write of 0x0004 coinciding with a new bit-2 rising edge → FLAGS still reads 0x0004.
- IRQ mask: with FLAGS=0x0002 and MASK=0, `irq`=0. Write MASK=0x0002 → `irq`=1 from the next cycle. Clear the flag → `irq`=0.
- Bus: a read of addr 3 returns 0x0000. A write to addr 0 leaves LEVEL unchanged. `data_out` holds its last read value through 5 idle cycles and through writes.
- With `SWITCHES_DEBOUNCE_EN` undefined: a 1-cycle-stable pulse on `sw_in[7]` → LEVEL bit 7 set at edge 3 and FLAGS reads 0x0080 at edge 4.
